// File: rtl/vregfile_mport_if.sv
// Operand/write bus of the vector-lane register file: two read ports (a, b),
// one byte-enabled write port (c) and the flash-clear strobe.
interface vregfile_mport_if #(
  parameter int WIDTH       = 32,
  parameter int LOG2NUMREGS = 4
);
  logic [LOG2NUMREGS-1:0] a_reg;
  logic                   a_en;
  logic [WIDTH-1:0]       a_readdataout;
  logic [LOG2NUMREGS-1:0] b_reg;
  logic                   b_en;
  logic [WIDTH-1:0]       b_readdataout;
  logic [LOG2NUMREGS-1:0] c_reg;
  logic [WIDTH-1:0]       c_writedatain;
  logic [WIDTH/8-1:0]     c_byteen;
  logic                   c_we;
  logic                   clear;

  modport master (
    output a_reg, a_en, b_reg, b_en,
    output c_reg, c_writedatain, c_byteen, c_we, clear,
    input  a_readdataout, b_readdataout
  );

  modport slave (
    input  a_reg, a_en, b_reg, b_en,
    input  c_reg, c_writedatain, c_byteen, c_we, clear,
    output a_readdataout, b_readdataout
  );
endinterface

// File: rtl/vregfile_mport.sv
// Vector-lane register file: two registered read ports, one byte-enabled write
// port, per-register valid bits for single-cycle flash clear.
module vregfile_mport #(
  parameter int WIDTH       = 32,
  parameter int NUMREGS     = 16,
  parameter int LOG2NUMREGS = 4,
  parameter int BYPASS      = 0
) (
  input  logic             clk,
  input  logic             resetn,
  vregfile_mport_if.slave  bus
);
  localparam int NBYTES = WIDTH / 8;

  logic [WIDTH-1:0]   regs [NUMREGS];
  logic [NUMREGS-1:0] valid;
  logic [NUMREGS-1:0] valid_next;
  logic [NUMREGS-1:0] wr_sel;
  logic               c_hit;
  logic [WIDTH-1:0]   a_old, b_old, c_old, c_merged;
  logic [WIDTH-1:0]   a_new, b_new, a_rd, b_rd;
  logic [WIDTH-1:0]   a_q, b_q;

  // Invalid registers and out-of-range addresses both read as zero.
  function automatic logic [WIDTH-1:0] logical_value(input logic [LOG2NUMREGS-1:0] addr);
    logic [WIDTH-1:0] v;
    v = '0;
    for (int i = 0; i < NUMREGS; i++) begin
      if (addr == LOG2NUMREGS'(i) && valid[i]) v = regs[i];
    end
    return v;
  endfunction

  always_comb begin
    a_old = logical_value(bus.a_reg);
    b_old = logical_value(bus.b_reg);
    c_old = logical_value(bus.c_reg);

    c_merged = c_old;
    for (int i = 0; i < NBYTES; i++) begin
      if (bus.c_byteen[i]) c_merged[8*i +: 8] = bus.c_writedatain[8*i +: 8];
    end

    wr_sel = '0;
    for (int i = 0; i < NUMREGS; i++) begin
      wr_sel[i] = bus.c_we && (bus.c_reg == LOG2NUMREGS'(i));
    end
    c_hit = |wr_sel;

    valid_next = (bus.clear ? '0 : valid) | wr_sel;

    // Post-edge view of each read address, used only in bypass mode.
    a_new = (c_hit && bus.a_reg == bus.c_reg) ? c_merged : (bus.clear ? '0 : a_old);
    b_new = (c_hit && bus.b_reg == bus.c_reg) ? c_merged : (bus.clear ? '0 : b_old);

    a_rd = (BYPASS != 0) ? a_new : a_old;
    b_rd = (BYPASS != 0) ? b_new : b_old;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid <= '0;
      a_q   <= '0;
      b_q   <= '0;
    end else begin
      valid <= valid_next;
      if (bus.a_en) a_q <= a_rd;
      if (bus.b_en) b_q <= b_rd;
    end
  end

  // Storage is never reset; the valid vector alone decides what reads see.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUMREGS; i++) begin
      if (wr_sel[i]) regs[i] <= c_merged;
    end
  end

  assign bus.a_readdataout = a_q;
  assign bus.b_readdataout = b_q;
endmodule

// File: tb/tb_vregfile_mport.sv
// Bench for vregfile_mport: one instance per read-during-write mode, driven
// identically and checked against vector tables and a logical-value model.
module tb_vregfile_mport;
  localparam int NR = 14;

  typedef struct {
    logic [3:0]  a_reg;
    logic        a_en;
    logic [3:0]  b_reg;
    logic        b_en;
    logic [3:0]  c_reg;
    logic [31:0] wd;
    logic [3:0]  be;
    logic        we;
    logic        clr;
    logic [31:0] ea0, eb0, ea1, eb1;
  } vec_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] mdl [NR];
  logic [31:0] exp_a0, exp_b0, exp_a1, exp_b1;
  vec_t        table_v [16];

  always #5 clk = ~clk;

  vregfile_mport_if #(.WIDTH(32), .LOG2NUMREGS(4)) if0 ();
  vregfile_mport_if #(.WIDTH(32), .LOG2NUMREGS(4)) if1 ();

  vregfile_mport #(.WIDTH(32), .NUMREGS(NR), .LOG2NUMREGS(4), .BYPASS(0)) dut0 (
    .clk(clk), .resetn(resetn), .bus(if0));
  vregfile_mport #(.WIDTH(32), .NUMREGS(NR), .LOG2NUMREGS(4), .BYPASS(1)) dut1 (
    .clk(clk), .resetn(resetn), .bus(if1));

  function automatic vec_t row(input logic [3:0] ar, input logic ae, input logic [3:0] br,
                               input logic be_n, input logic [3:0] cr, input logic [31:0] wd,
                               input logic [3:0] be, input logic we, input logic clr,
                               input logic [31:0] ea0, input logic [31:0] eb0,
                               input logic [31:0] ea1, input logic [31:0] eb1);
    vec_t v;
    v.a_reg = ar; v.a_en = ae; v.b_reg = br; v.b_en = be_n;
    v.c_reg = cr; v.wd = wd; v.be = be; v.we = we; v.clr = clr;
    v.ea0 = ea0; v.eb0 = eb0; v.ea1 = ea1; v.eb1 = eb1;
    return v;
  endfunction

  function automatic vec_t wr(input logic [3:0] cr, input logic [31:0] wd, input logic [3:0] be);
    return row(4'd0, 1'b0, 4'd0, 1'b0, cr, wd, be, 1'b1, 1'b0, '0, '0, '0, '0);
  endfunction

  function automatic vec_t rd(input logic [3:0] ar, input logic [3:0] br);
    return row(ar, 1'b1, br, 1'b1, 4'd0, '0, 4'h0, 1'b0, 1'b0, '0, '0, '0, '0);
  endfunction

  function automatic logic [31:0] merge(input logic [3:0] be, input logic [31:0] wd,
                                        input logic [31:0] old);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = be[i] ? wd[8*i +: 8] : old[8*i +: 8];
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NR; i++) mdl[i] = '0;
    exp_a0 = '0; exp_b0 = '0; exp_a1 = '0; exp_b1 = '0;
  endtask

  // Spec-level model: pre-edge and post-edge logical register files.
  task automatic model_edge(input vec_t v);
    logic [31:0] post [NR];
    for (int i = 0; i < NR; i++) post[i] = v.clr ? 32'h0 : mdl[i];
    if (v.we && int'(v.c_reg) < NR) post[v.c_reg] = merge(v.be, v.wd, mdl[v.c_reg]);
    if (v.a_en) begin
      exp_a0 = (int'(v.a_reg) < NR) ? mdl[v.a_reg]  : 32'h0;
      exp_a1 = (int'(v.a_reg) < NR) ? post[v.a_reg] : 32'h0;
    end
    if (v.b_en) begin
      exp_b0 = (int'(v.b_reg) < NR) ? mdl[v.b_reg]  : 32'h0;
      exp_b1 = (int'(v.b_reg) < NR) ? post[v.b_reg] : 32'h0;
    end
    for (int i = 0; i < NR; i++) mdl[i] = post[i];
  endtask

  task automatic drive(input vec_t v);
    if0.a_reg = v.a_reg; if0.a_en = v.a_en; if0.b_reg = v.b_reg; if0.b_en = v.b_en;
    if0.c_reg = v.c_reg; if0.c_writedatain = v.wd; if0.c_byteen = v.be;
    if0.c_we = v.we; if0.clear = v.clr;
    if1.a_reg = v.a_reg; if1.a_en = v.a_en; if1.b_reg = v.b_reg; if1.b_en = v.b_en;
    if1.c_reg = v.c_reg; if1.c_writedatain = v.wd; if1.c_byteen = v.be;
    if1.c_we = v.we; if1.clear = v.clr;
  endtask

  // One clock edge: inputs set at negedge, outputs sampled 1 ns after posedge.
  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    drive(v);
    @(posedge clk);
    model_edge(v);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic checkAll(input string tag, input logic [31:0] ea0, input logic [31:0] eb0,
                          input logic [31:0] ea1, input logic [31:0] eb1);
    checkOutput({tag, " a/bypass0"}, if0.a_readdataout, ea0);
    checkOutput({tag, " b/bypass0"}, if0.b_readdataout, eb0);
    checkOutput({tag, " a/bypass1"}, if1.a_readdataout, ea1);
    checkOutput({tag, " b/bypass1"}, if1.b_readdataout, eb1);
  endtask

  function automatic logic [31:0] fill_val(input int i);
    return 32'h1000_0000 + 32'(i) * 32'h0101_0101;
  endfunction

  initial begin
    vec_t v;
    drive(row(4'd0, 1'b0, 4'd0, 1'b0, 4'd0, '0, 4'h0, 1'b0, 1'b0, '0, '0, '0, '0));
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    #1;
    checkAll("reset", '0, '0, '0, '0);

    // Garbage in every register with all bytes nonzero, then async reset.
    for (int i = 0; i < NR; i++) applyStimulus(wr(4'(i), 32'hA5C3_9E00 | 32'(i + 1), 4'hF));
    applyStimulus(rd(4'd1, 4'd2));
    checkAll("garbage read", exp_a0, exp_b0, exp_a1, exp_b1);
    #3;
    drive(row(4'd0, 1'b0, 4'd0, 1'b0, 4'd0, '0, 4'h0, 1'b0, 1'b0, '0, '0, '0, '0));
    resetn = 1'b0;
    #1;
    checkAll("async reset", '0, '0, '0, '0);
    model_reset();
    #1;
    resetn = 1'b1;

    // First write after release: register is invalid, so unenabled bytes are zero.
    applyStimulus(wr(4'd1, 32'h0000_7700, 4'b0010));
    applyStimulus(rd(4'd1, 4'd1));
    checkAll("write after reset", 32'h0000_7700, 32'h0000_7700, 32'h0000_7700, 32'h0000_7700);

    table_v[0]  = row(4'd0, 1, 4'd15, 1, 4'd0, '0, 4'h0, 0, 0, '0, '0, '0, '0);
    table_v[1]  = row(4'd13, 1, 4'd14, 1, 4'd0, '0, 4'h0, 0, 0, '0, '0, '0, '0);
    table_v[2]  = row(4'd0, 0, 4'd0, 0, 4'd3, 32'hDEADBEEF, 4'hF, 1, 0, '0, '0, '0, '0);
    table_v[3]  = row(4'd3, 1, 4'd3, 1, 4'd0, '0, 4'h0, 0, 0,
                      32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF);
    table_v[4]  = row(4'd0, 0, 4'd0, 0, 4'd0, '0, 4'h0, 0, 0,
                      32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF);
    table_v[5]  = row(4'd0, 0, 4'd0, 0, 4'd5, 32'h11223344, 4'b0101, 1, 0,
                      32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF);
    table_v[6]  = row(4'd5, 1, 4'd3, 1, 4'd5, 32'hAABBCCDD, 4'b1000, 1, 0,
                      32'h00220044, 32'hDEADBEEF, 32'hAA220044, 32'hDEADBEEF);
    table_v[7]  = row(4'd5, 1, 4'd5, 1, 4'd0, '0, 4'h0, 0, 0,
                      32'hAA220044, 32'hAA220044, 32'hAA220044, 32'hAA220044);
    table_v[8]  = row(4'd0, 0, 4'd0, 0, 4'd7, 32'hCAFEF00D, 4'hF, 1, 0,
                      32'hAA220044, 32'hAA220044, 32'hAA220044, 32'hAA220044);
    table_v[9]  = row(4'd7, 1, 4'd0, 0, 4'd7, 32'h12345678, 4'hF, 1, 0,
                      32'hCAFEF00D, 32'hAA220044, 32'h12345678, 32'hAA220044);
    table_v[10] = row(4'd7, 1, 4'd7, 1, 4'd0, '0, 4'h0, 0, 0,
                      32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678);
    table_v[11] = row(4'd14, 1, 4'd13, 1, 4'd14, 32'hFFFFFFFF, 4'hF, 1, 0, '0, '0, '0, '0);
    table_v[12] = row(4'd9, 1, 4'd9, 1, 4'd9, 32'hFFFFFFFF, 4'h0, 1, 0, '0, '0, '0, '0);
    table_v[13] = row(4'd0, 0, 4'd0, 0, 4'd9, 32'h000000AA, 4'b0001, 1, 0, '0, '0, '0, '0);
    table_v[14] = row(4'd9, 1, 4'd9, 1, 4'd0, '0, 4'h0, 0, 0,
                      32'h000000AA, 32'h000000AA, 32'h000000AA, 32'h000000AA);
    table_v[15] = row(4'd15, 1, 4'd1, 1, 4'd0, '0, 4'h0, 0, 0,
                      '0, 32'h00007700, '0, 32'h00007700);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(table_v[i]);
      checkAll($sformatf("row%0d", i), table_v[i].ea0, table_v[i].eb0,
               table_v[i].ea1, table_v[i].eb1);
    end

    // Flash clear with a same-cycle write of r2 and reads of r4 and r2.
    for (int i = 0; i < NR; i++) applyStimulus(wr(4'(i), fill_val(i), 4'hF));
    applyStimulus(row(4'd4, 1, 4'd2, 1, 4'd2, 32'h0000FFFF, 4'hF, 1, 1, '0, '0, '0, '0));
    checkAll("clear+write", fill_val(4), fill_val(2), 32'h0, 32'h0000FFFF);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(rd(4'(i), 4'(i)));
      v.ea0 = (i == 2) ? 32'h0000FFFF : 32'h0;
      checkAll($sformatf("after clear r%0d", i), v.ea0, v.ea0, v.ea0, v.ea0);
    end
    applyStimulus(row(4'd2, 1, 4'd0, 0, 4'd0, '0, 4'h0, 0, 1, '0, '0, '0, '0));
    checkAll("clear1", 32'h0000FFFF, 32'h0, 32'h0, 32'h0);
    applyStimulus(row(4'd0, 0, 4'd6, 1, 4'd6, 32'hABCD1234, 4'b1100, 1, 1, '0, '0, '0, '0));
    checkAll("clear2", 32'h0000FFFF, 32'h0, 32'h0, 32'hABCD0000);
    applyStimulus(rd(4'd2, 4'd6));
    checkAll("after clears", 32'h0, 32'hABCD0000, 32'h0, 32'hABCD0000);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      v.a_reg = 4'($urandom_range(0, 15));
      v.a_en  = 1'($urandom_range(0, 1));
      v.b_reg = (($urandom_range(0, 3)) == 0) ? v.a_reg : 4'($urandom_range(0, 15));
      v.b_en  = 1'($urandom_range(0, 1));
      v.c_reg = (($urandom_range(0, 2)) == 0) ? v.a_reg : 4'($urandom_range(0, 15));
      v.wd    = $urandom;
      v.be    = 4'($urandom_range(0, 15));
      v.we    = 1'($urandom_range(0, 1));
      v.clr   = ($urandom_range(0, 15) == 0);
      applyStimulus(v);
      checkAll($sformatf("rand%0d", n), exp_a0, exp_b0, exp_a1, exp_b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
